// File: rtl/gru_uart_host.sv
// gru_uart_host: streams a payload RAM to a GRU target over 8N1 UART and
// collects result words. Optional RECV watchdog: GRU_HOST_TIMEOUT_EN.
module gru_uart_host #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int TX_WORDS     = 33,
    parameter int RX_WORDS     = 12,
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_wr_en,
    input  logic [5:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic        i_start,
    input  logic [3:0]  i_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_uart_tx,
    input  logic        i_uart_rx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout_err
);
    localparam int CW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TBW = $clog2(4 * TX_WORDS + 1);
    localparam int RBW = $clog2(4 * RX_WORDS + 1);
    localparam int TAW = (TX_WORDS > 1) ? $clog2(TX_WORDS) : 1;
    localparam int RAW = (RX_WORDS > 1) ? $clog2(RX_WORDS) : 1;
    localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TBW-1:0] TX_LAST  = TBW'(4 * TX_WORDS - 1);
    localparam logic [RBW-1:0] RX_LAST  = RBW'(4 * RX_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

    state_t         state, state_nx;
    rx_state_t      rx_st, rx_st_nx;
    logic [31:0]    tx_mem [TX_WORDS];
    logic [31:0]    rx_mem [RX_WORDS];
    logic [CW-1:0]  tx_clk, rx_clk;
    logic [3:0]     tx_bit;
    logic [TBW-1:0] tx_byte;
    logic [31:0]    tx_word, rx_word;
    logic [7:0]     tx_cur, rx_sh;
    logic [2:0]     rx_bit;
    logic [RBW-1:0] rx_cnt;
    logic [RAW-1:0] wr_idx;
    logic           tx_val, tx_bit_end, tx_end, start;
    logic           rx_s1, rx_s2, rx_s3, rx_valid, wr_pend, to_hit;

    assign start      = (state == IDLE) && i_start;
    assign o_busy     = (state == SEND) || (state == RECV);
    assign o_done     = (state == DONE);
    assign tx_word    = tx_mem[TAW'(tx_byte >> 2)];
    assign tx_cur     = tx_word[{tx_byte[1:0], 3'b000} +: 8];
    assign tx_bit_end = (tx_clk == BIT_END);
    assign tx_end     = tx_bit_end && (tx_bit == 4'd9) && (tx_byte == TX_LAST);

    // Frame slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_comb begin
        tx_val = 1'b1;
        if (tx_bit == 4'd0)
            tx_val = 1'b0;
        else if (tx_bit <= 4'd8)
            tx_val = tx_cur[3'(tx_bit - 4'd1)];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (i_start) state_nx = SEND;
            SEND: if (tx_end) state_nx = RECV;
            RECV: begin
                if (rx_valid && rx_cnt == RX_LAST)
                    state_nx = DONE;
                else if (to_hit)
                    state_nx = IDLE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rx_st_nx = rx_st;
        unique case (rx_st)
            R_IDLE:  if (!rx_s2 && rx_s3) rx_st_nx = R_START;
            R_START: if (rx_clk == HALF_END) rx_st_nx = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_clk == BIT_END && rx_bit == 3'd7) rx_st_nx = R_STOP;
            R_STOP:  if (rx_clk == BIT_END) rx_st_nx = rx_s2 ? R_IDLE : R_WAIT;
            R_WAIT:  if (rx_s2) rx_st_nx = R_IDLE;
            default: rx_st_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_st    <= R_IDLE;
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= i_uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_st    <= rx_st_nx;
            rx_valid <= 1'b0;
            unique case (rx_st)
                R_START: rx_clk <= (rx_clk == HALF_END) ? '0 : rx_clk + 1'b1;
                R_DATA: begin
                    if (rx_clk == BIT_END) begin
                        rx_clk <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_clk <= rx_clk + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_clk == BIT_END) begin
                        rx_clk   <= '0;
                        rx_valid <= rx_s2;
                    end else begin
                        rx_clk <= rx_clk + 1'b1;
                    end
                end
                default: begin
                    rx_clk <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            tx_clk    <= '0;
            tx_bit    <= '0;
            tx_byte   <= '0;
            rx_cnt    <= '0;
            rx_word   <= '0;
            wr_pend   <= 1'b0;
            wr_idx    <= '0;
            o_uart_tx <= 1'b1;
            o_rd_data <= '0;
        end else begin
            state     <= state_nx;
            wr_pend   <= 1'b0;
            o_uart_tx <= (state == SEND) ? tx_val : 1'b1;
            o_rd_data <= (32'(i_rd_addr) < RX_WORDS) ? rx_mem[RAW'(i_rd_addr)] : '0;
            if (start) begin
                tx_clk  <= '0;
                tx_bit  <= '0;
                tx_byte <= '0;
                rx_cnt  <= '0;
            end else if (state == SEND) begin
                if (tx_bit_end) begin
                    tx_clk <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit  <= '0;
                        tx_byte <= tx_byte + 1'b1;
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_clk <= tx_clk + 1'b1;
                end
            end
            // Bytes shift in from the top so byte 0 ends up in bits 7:0.
            if (state == RECV && rx_valid) begin
                rx_word <= {rx_sh, rx_word[31:8]};
                rx_cnt  <= rx_cnt + 1'b1;
                if (rx_cnt[1:0] == 2'd3) begin
                    wr_pend <= 1'b1;
                    wr_idx  <= RAW'(rx_cnt >> 2);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en && !o_busy && 32'(i_wr_addr) < TX_WORDS)
            tx_mem[TAW'(i_wr_addr)] <= i_wr_data;
        if (wr_pend)
            rx_mem[wr_idx] <= rx_word;
    end

`ifdef GRU_HOST_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CLKS + 1);
    logic [TOW-1:0] to_cnt;
    logic           to_err;

    assign to_hit        = (state == RECV) && (to_cnt == TOW'(TIMEOUT_CLKS - 1));
    assign o_timeout_err = to_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            to_cnt <= (state != RECV || rx_valid) ? '0 : to_cnt + 1'b1;
            if (start)
                to_err <= 1'b0;
            else if (to_hit && state_nx == IDLE)
                to_err <= 1'b1;
        end
    end
`else
    assign to_hit        = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_gru_uart_host.sv
// tb_gru_uart_host: directed bench with TX byte and result word scoreboards,
// a serial loopback driver and a frame monitor for gru_uart_host.
module tb_gru_uart_host;
    localparam int CPB   = 16;
    localparam int TXW   = 33;
    localparam int RXW   = 12;
    localparam int TOC   = 4000;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [5:0]  i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic        i_start = 1'b0;
    logic [3:0]  i_rd_addr = '0;
    logic [31:0] o_rd_data;
    logic        o_uart_tx;
    logic        i_uart_rx = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout_err;

    gru_uart_host #(
        .CLKS_PER_BIT(CPB),
        .TX_WORDS(TXW),
        .RX_WORDS(RXW),
        .TIMEOUT_CLKS(TOC)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .i_start(i_start),
        .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data),
        .o_uart_tx(o_uart_tx),
        .i_uart_rx(i_uart_rx),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cycles = 0;
    int          tx_frames = 0;
    int          last_start = 0;
    bit          tx_link = 1'b0;
    logic [7:0]  exp_tx [$];
    logic [31:0] exp_rd [$];
    logic [31:0] pay [TXW];
    int          mon_t0;
    logic        mon_ok, mon_start, mon_stop;
    logic [7:0]  mon_b;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_done) done_cycles <= done_cycles + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!rstn) mon_ok = 1'b0;
        end
    endtask

    // Decodes every frame on o_uart_tx and checks it against the byte queue.
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (rstn && o_uart_tx === 1'b0) begin
                mon_t0 = cyc;
                mon_ok = 1'b1;
                if (tx_link) chk("tx_gap", 32'(mon_t0 - last_start), FRAME);
                mon_wait(CPB / 2);
                mon_start = o_uart_tx;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB);
                    mon_b[i] = o_uart_tx;
                end
                mon_wait(CPB);
                mon_stop = o_uart_tx;
                if (mon_ok) begin
                    tx_frames++;
                    last_start = mon_t0;
                    tx_link = 1'b1;
                    chk("tx_start_bit", 32'(mon_start), 0);
                    chk("tx_stop_bit", 32'(mon_stop), 1);
                    checks++;
                    assert (exp_tx.size() > 0) else begin
                        errors++;
                        $error("FAIL tx_extra: observed byte %0h expected none", mon_b);
                    end
                    if (exp_tx.size() > 0) chk("tx_byte", 32'(mon_b), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        i_uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            tick(CPB);
        end
        i_uart_rx = stop_bit;
        tick(CPB);
        i_uart_rx = 1'b1;
    endtask

    task automatic push_payload();
        for (int w = 0; w < TXW; w++)
            for (int k = 0; k < 4; k++)
                exp_tx.push_back(pay[w][8*k +: 8]);
    endtask

    task automatic start_txn();
        tx_link = 1'b0;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n;
        n = 0;
        while (tx_frames < target && n < 25000) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(tx_frames), 32'(target));
    endtask

    task automatic read_chk(input int a, input string tag);
        i_rd_addr = 4'(a);
        tick(1);
        chk(tag, o_rd_data, exp_rd.pop_front());
    endtask

    initial begin
        int n;
        for (int i = 0; i < TXW; i++) pay[i] = 32'h9E3779B9 * 32'(i + 1);
        pay[0] = 32'h11223344;
        pay[2] = 32'h5A00C3A5;

        tick(3);
        chk("rst_tx", 32'(o_uart_tx), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_timeout_err), 0);
        chk("rst_rd", o_rd_data, 0);
        rstn = 1'b1;
        tick(2);

        for (int i = 0; i < TXW; i++) begin
            i_wr_en = 1'b1;
            i_wr_addr = 6'(i);
            i_wr_data = pay[i];
            tick(1);
        end
        i_wr_en = 1'b0;

        push_payload();
        start_txn();
        tick(2);
        chk("t1_busy_send", 32'(o_busy), 1);
        i_wr_en = 1'b1;
        i_wr_addr = 6'd0;
        i_wr_data = 32'hDEADBEEF;
        tick(1);
        i_wr_en = 1'b0;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        send_byte(8'hEE, 1'b1);
        wait_frames(132, "t1_frames");
        tick(20);
        chk("t1_busy_recv", 32'(o_busy), 1);

        i_uart_rx = 1'b0;
        tick(2);
        i_uart_rx = 1'b1;
        tick(40);
        send_byte(8'h5C, 1'b0);
        tick(40);
        for (int k = 0; k < 4 * RXW; k++) send_byte(8'(k), 1'b1);
        tick(10);
        chk("t1_done_pulse", 32'(done_cycles), 1);
        chk("t1_idle", 32'(o_busy), 0);
        chk("t1_frame_total", 32'(tx_frames), 132);
        for (int w = 0; w < RXW; w++)
            exp_rd.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        exp_rd.push_back(32'h0);
        exp_rd.push_back(32'h0);
        for (int w = 0; w < RXW; w++) read_chk(w, "t1_result");
        read_chk(12, "rd_oob12");
        read_chk(15, "rd_oob15");

        i_rd_addr = 4'd0;
        push_payload();
        start_txn();
        wait_frames(142, "t2_frames");
        tick(44);
        chk("t2_line_low", 32'(o_uart_tx), 0);
        rstn = 1'b0;
        #1;
        chk("t2_rst_tx", 32'(o_uart_tx), 1);
        chk("t2_rst_busy", 32'(o_busy), 0);
        chk("t2_rst_rd", o_rd_data, 0);
        tick(40);
        exp_tx.delete();
        rstn = 1'b1;
        tick(200);
        chk("t2_line_idle", 32'(o_uart_tx), 1);

        push_payload();
        start_txn();
        wait_frames(274, "t3_frames");
        tick(20);
        for (int k = 0; k < 4 * RXW - 1; k++) send_byte(8'(8'h80 + k), 1'b1);
`ifdef GRU_HOST_TIMEOUT_EN
        n = 0;
        while (o_busy && n < TOC + 1000) begin
            tick(1);
            n++;
        end
        chk("to_idle", 32'(o_busy), 0);
        chk("to_err", 32'(o_timeout_err), 1);
        chk("to_no_done", 32'(done_cycles), 1);
        exp_rd.push_back(32'h83828180);
        exp_rd.push_back(32'hABAAA9A8);
        exp_rd.push_back(32'h2F2E2D2C);
        read_chk(0, "t3_result0");
        read_chk(10, "t3_result10");
        read_chk(11, "t3_result11");
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        chk("to_err_clear", 32'(o_timeout_err), 0);
        rstn = 1'b0;
        tick(5);
        rstn = 1'b1;
        tick(200);
`else
        tick(TOC + 1000);
        chk("no_to_busy", 32'(o_busy), 1);
        chk("no_to_err", 32'(o_timeout_err), 0);
        chk("no_to_no_done", 32'(done_cycles), 1);
        send_byte(8'hAF, 1'b1);
        tick(10);
        chk("t3_done_pulse", 32'(done_cycles), 2);
        chk("t3_idle", 32'(o_busy), 0);
        exp_rd.push_back(32'h83828180);
        exp_rd.push_back(32'hABAAA9A8);
        exp_rd.push_back(32'hAFAEADAC);
        read_chk(0, "t3_result0");
        read_chk(10, "t3_result10");
        read_chk(11, "t3_result11");
`endif
        chk("tx_frame_total", 32'(tx_frames), 274);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gru_uart_host.md
GRU_UART_HOST -- requirements
Module: gru_uart_host

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, clocks per UART bit (8N1).
REQ-002 SHALL have parameter TX_WORDS, default 33, 32-bit payload words sent per transaction.
REQ-003 SHALL have parameter RX_WORDS, default 12, 32-bit result words expected per transaction.
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 2000000, idle-line clocks before abort (REQ-025).
REQ-005 SHALL use one clock and an asynchronous active-low reset; ports:
- clk  input  1  sole clock, rising edge
- rstn  input  1  asynchronous active-low reset
- i_wr_en  input  1  payload RAM write strobe
- i_wr_addr  input  6  payload word address
- i_wr_data  input  32  payload word
- i_start  input  1  single-cycle transaction request
- i_rd_addr  input  4  result word address
- o_rd_data  output  32  result word, registered
- o_uart_tx  output  1  serial out to GRU target
- i_uart_rx  input  1  serial in from GRU target
- o_busy  output  1  transaction in progress
- o_done  output  1  one-cycle completion pulse
- o_timeout_err  output  1  sticky timeout flag

Function
REQ-006 SHALL hold a TX_WORDS x 32 payload RAM and an RX_WORDS x 32 result RAM.
REQ-007 SHALL write payload RAM on i_wr_en only when o_busy=0; writes while busy ignored; address >= TX_WORDS ignored.
REQ-008 SHALL present result RAM[i_rd_addr] on o_rd_data one cycle after the address; address >= RX_WORDS reads 0.
REQ-009 SHALL implement FSM states IDLE, SEND, RECV, DONE.
REQ-010 IDLE -> SEND on i_start=1; i_start ignored in any other state.
REQ-011 SEND SHALL transmit payload words in address order 0..TX_WORDS-1, each word as 4 bytes LSB first (bits 7:0 first).
REQ-012 SEND -> RECV when the stop bit of byte 4*TX_WORDS-1 completes; total bytes sent SHALL be exactly 4*TX_WORDS.
REQ-013 RECV SHALL assemble bytes LSB first into words: byte k lands in word k/4, bits 8*(k%4)+7:8*(k%4).
REQ-014 RECV SHALL write each word to result RAM in the cycle after its 4th byte is received.
REQ-015 RECV -> DONE after byte 4*RX_WORDS-1; DONE -> IDLE after one cycle; o_done=1 exactly during DONE.
REQ-016 Bytes arriving in IDLE or SEND SHALL be discarded, with no result RAM writes.
REQ-017 o_busy SHALL be 1 in SEND and RECV, 0 otherwise.
REQ-018 UART TX frame: start bit 0, 8 data bits LSB first, 1 stop bit 1, each CLKS_PER_BIT clocks; next byte's start bit SHALL follow its predecessor's stop bit with zero gap; line idles at 1.
REQ-019 UART RX SHALL pass i_uart_rx through a 2-flop synchronizer, detect the falling edge, and recheck at CLKS_PER_BIT/2.
REQ-020 A start bit that is not 0 at recheck SHALL be rejected as a glitch and RX SHALL return to idle.
REQ-021 RX SHALL sample data bits at bit centres.
REQ-022 A stop bit that samples 0 SHALL discard the byte, not advance the byte count, and wait for the line to return to 1.
REQ-023 Byte and word counters SHALL cover 4*TX_WORDS and 4*RX_WORDS with no wrap within a transaction; they SHALL clear on entry to SEND.

Reset
REQ-024 On rstn=0, SHALL go to IDLE and set o_uart_tx=1, o_busy=0, o_done=0, o_timeout_err=0, o_rd_data=0, all counters 0, RAM contents unchanged; reset mid-frame SHALL abort the frame immediately, with no partial result write.

Configuration
REQ-025 With macro GRU_HOST_TIMEOUT_EN defined, a counter SHALL clear on every received byte and on RECV entry; on reaching TIMEOUT_CLKS in RECV, the FSM SHALL go to IDLE, set o_timeout_err=1 (cleared only by the next i_start or reset), and not pulse o_done.
REQ-026 Without GRU_HOST_TIMEOUT_EN, no timeout logic SHALL exist, o_timeout_err SHALL be tied 0, and RECV SHALL wait indefinitely.

Verification (CLKS_PER_BIT=16, TX_WORDS=33, RX_WORDS=12, TIMEOUT_CLKS=4000)
REQ-027 Load word0=0x11223344, then i_start -> first bytes on line 0x44,0x33,0x22,0x11; 132 frames of 160 clocks each, back to back; o_busy=1.
REQ-028 Loopback model returns 48 bytes 0x00..0x2F -> result[0]=0x03020100, result[11]=0x2F2E2D2C; o_done pulses once, 1 cycle.
REQ-029 2-clock low glitch on i_uart_rx in RECV -> no byte counted; a byte with stop bit forced 0 -> discarded, count unchanged.
REQ-030 Model returns only 47 bytes, macro defined -> after 4000 idle clocks o_timeout_err=1, FSM in IDLE, o_done stays 0; macro undefined -> o_busy stays 1.
REQ-031 rstn asserted mid-SEND byte 10 -> o_uart_tx=1 at once, o_busy=0; payload RAM intact; a new i_start resends from byte 0.
REQ-032 i_wr_en to addr 0 while busy -> payload RAM[0] unchanged on the next transaction.
